// File: rtl/sram_burst_master.sv
// sram_burst_master: host-side burst client for the asynchronous SRAM controller.
// A command of BURST words goes through a local buffer. Write data is collected
// from the in_* stream and then played out on ctl_wr_valid_i. Read data is
// captured on ctl_rd_valid_i and then drained to the out_* stream.
// Ports:
//   sys_clk, sys_rst_n             clock, async active-low reset
//   cmd_valid_i/cmd_ready_o        command handshake (cmd_rw_i: 1=write, cmd_addr_i)
//   in_valid_i/in_ready_o/in_data_i     write-data stream
//   out_valid_o/out_ready_i/out_data_o  read-data stream
//   done_o, err_o                  completion / timeout-abort pulses
//   ctl_*                          controller system-side port
module sram_burst_master #(
  parameter int unsigned BURST   = 16,
  parameter int unsigned AW      = 18,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_rw_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic          done_o,
  output logic          err_o,
  output logic          ctl_rreq_o,
  output logic          ctl_wreq_o,
  output logic [AW-1:0] ctl_rd_addr_o,
  output logic [AW-1:0] ctl_wr_addr_o,
  output logic [DW-1:0] ctl_wdata_o,
  input  logic [DW-1:0] ctl_rdata_i,
  input  logic          ctl_rd_valid_i,
  input  logic          ctl_wr_valid_i,
  input  logic          ctl_rd_ack_i,
  input  logic          ctl_wr_ack_i
);

  localparam int unsigned PW   = $clog2(BURST);
  localparam int unsigned PTRW = PW + 1;  // read count must reach BURST
  localparam int unsigned TW   = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WREQ, S_RREQ, S_DRAIN, S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [PTRW-1:0] ptr_q, ptr_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            rdy_q, rreq_q, wreq_q, done_q, err_q;
  logic            done_d, err_d;
  logic [AW-1:0]   addr_q;
  logic            addr_ld;
  logic            mem_we;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_q [BURST];

  // Next-state, pointer and timeout decode
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    tcnt_d    = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    addr_ld   = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = in_data_i;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && rdy_q) begin
          addr_ld = 1'b1;
          ptr_d   = '0;
          state_d = cmd_rw_i ? S_FILL : S_RREQ;
        end
      end
      S_FILL: begin
        if (in_valid_i) begin
          mem_we = 1'b1;
          if (ptr_q == PTRW'(BURST - 1)) begin
            ptr_d   = '0;
            state_d = S_WREQ;
          end else begin
            ptr_d = ptr_q + PTRW'(1);
          end
        end
      end
      S_WREQ: begin
        tcnt_d = tcnt_q + TW'(1);
        // Pointer parks on the last word once the burst has been strobed out
        if (ctl_wr_valid_i && (ptr_q != PTRW'(BURST - 1))) begin
          ptr_d = ptr_q + PTRW'(1);
        end
        if (ctl_wr_ack_i) begin
          state_d = S_GAP;
          done_d  = 1'b1;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = S_GAP;
          err_d   = 1'b1;
        end
      end
      S_RREQ: begin
        tcnt_d = tcnt_q + TW'(1);
        // Strobes beyond the burst length are dropped
        if (ctl_rd_valid_i && (ptr_q < PTRW'(BURST))) begin
          mem_we    = 1'b1;
          mem_wdata = ctl_rdata_i;
          ptr_d     = ptr_q + PTRW'(1);
        end
        if (ctl_rd_ack_i) begin
          ptr_d   = '0;
          state_d = S_DRAIN;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = S_GAP;
          err_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (out_ready_i) begin
          if (ptr_q == PTRW'(BURST - 1)) begin
            state_d = S_GAP;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + PTRW'(1);
          end
        end
      end
      S_GAP: begin
        // One cycle with both requests low gives the controller a fresh edge
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      tcnt_q  <= '0;
      rdy_q   <= 1'b0;
      rreq_q  <= 1'b0;
      wreq_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
      rdy_q   <= (state_d == S_IDLE);
      rreq_q  <= (state_d == S_RREQ);
      wreq_q  <= (state_d == S_WREQ);
      done_q  <= done_d;
      err_q   <= err_d;
      if (addr_ld) begin
        addr_q <= cmd_addr_i;
      end
    end
  end

  // Burst buffer, contents undefined after reset
  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      mem_q[ptr_q[PW-1:0]] <= mem_wdata;
    end
  end

  assign cmd_ready_o   = rdy_q;
  assign in_ready_o    = (state_q == S_FILL);
  assign out_valid_o   = (state_q == S_DRAIN);
  assign out_data_o    = out_valid_o ? mem_q[ptr_q[PW-1:0]] : '0;
  assign ctl_wdata_o   = (state_q == S_WREQ) ? mem_q[ptr_q[PW-1:0]] : '0;
  assign ctl_rreq_o    = rreq_q;
  assign ctl_wreq_o    = wreq_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign ctl_rd_addr_o = addr_q;
  assign ctl_wr_addr_o = addr_q;

endmodule

// File: tb/tb_sram_burst_master.sv
// Directed bench for sram_burst_master (BURST=16, TIMEOUT=20). Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_sram_burst_master;

  localparam int unsigned BURST   = 16;
  localparam int unsigned AW      = 18;
  localparam int unsigned DW      = 16;
  localparam int unsigned TIMEOUT = 20;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          cmd_valid_i, cmd_ready_o, cmd_rw_i;
  logic [AW-1:0] cmd_addr_i;
  logic          in_valid_i, in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o, out_ready_i;
  logic [DW-1:0] out_data_o;
  logic          done_o, err_o;
  logic          ctl_rreq_o, ctl_wreq_o;
  logic [AW-1:0] ctl_rd_addr_o, ctl_wr_addr_o;
  logic [DW-1:0] ctl_wdata_o, ctl_rdata_i;
  logic          ctl_rd_valid_i, ctl_wr_valid_i, ctl_rd_ack_i, ctl_wr_ack_i;

  int vectors     = 0;
  int miscompares = 0;

  always #5 sys_clk = ~sys_clk;

  sram_burst_master #(
    .BURST(BURST), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_rw_i(cmd_rw_i), .cmd_addr_i(cmd_addr_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .done_o(done_o), .err_o(err_o),
    .ctl_rreq_o(ctl_rreq_o), .ctl_wreq_o(ctl_wreq_o),
    .ctl_rd_addr_o(ctl_rd_addr_o), .ctl_wr_addr_o(ctl_wr_addr_o),
    .ctl_wdata_o(ctl_wdata_o), .ctl_rdata_i(ctl_rdata_i),
    .ctl_rd_valid_i(ctl_rd_valid_i), .ctl_wr_valid_i(ctl_wr_valid_i),
    .ctl_rd_ack_i(ctl_rd_ack_i), .ctl_wr_ack_i(ctl_wr_ack_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic tick;
    @(negedge sys_clk);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    cmd_valid_i = 1'b0; cmd_rw_i = 1'b0; cmd_addr_i = '0;
    in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    ctl_rdata_i = '0; ctl_rd_valid_i = 1'b0; ctl_wr_valid_i = 1'b0;
    ctl_rd_ack_i = 1'b0; ctl_wr_ack_i = 1'b0;
    tick; tick;

    // Reset state
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    chk("rst_rreq",      32'(ctl_rreq_o),  32'd0);
    chk("rst_wreq",      32'(ctl_wreq_o),  32'd0);
    chk("rst_done",      32'(done_o),      32'd0);
    chk("rst_err",       32'(err_o),       32'd0);
    chk("rst_rd_addr",   32'(ctl_rd_addr_o), 32'd0);
    chk("rst_in_ready",  32'(in_ready_o),  32'd0);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    sys_rst_n = 1'b1;
    #1 chk("rel_ready_low", 32'(cmd_ready_o), 32'd0);
    tick;
    chk("rel_ready_high", 32'(cmd_ready_o), 32'd1);

    // Write burst to 0x00100
    cmd_valid_i = 1'b1; cmd_rw_i = 1'b1; cmd_addr_i = 18'h00100;
    tick;
    cmd_valid_i = 1'b0;
    chk("wr_addr",      32'(ctl_wr_addr_o), 32'h100);
    chk("wr_rd_addr",   32'(ctl_rd_addr_o), 32'h100);
    chk("fill_ready",   32'(in_ready_o),    32'd1);
    chk("fill_cmd_rdy", 32'(cmd_ready_o),   32'd0);
    for (int k = 0; k < 16; k++) begin
      chk("fill_no_wreq", 32'(ctl_wreq_o), 32'd0);
      in_valid_i = 1'b1; in_data_i = 16'(32'hA000 + k);
      tick;
    end
    in_valid_i = 1'b0;
    chk("wreq_rise",    32'(ctl_wreq_o), 32'd1);
    chk("fill_closed",  32'(in_ready_o), 32'd0);
    for (int k = 0; k < 16; k++) begin
      chk("wdata",     32'(ctl_wdata_o), 32'hA000 + 32'(k));
      chk("wreq_hold", 32'(ctl_wreq_o),  32'd1);
      ctl_wr_valid_i = 1'b1;
      tick;
    end
    ctl_wr_valid_i = 1'b0;
    chk("wdata_sat", 32'(ctl_wdata_o), 32'hA00F);
    // Read ack during WREQ must be ignored
    ctl_rd_ack_i = 1'b1;
    tick;
    ctl_rd_ack_i = 1'b0;
    chk("opp_ack_wreq",  32'(ctl_wreq_o),  32'd1);
    chk("opp_ack_done",  32'(done_o),      32'd0);
    chk("opp_ack_wdata", 32'(ctl_wdata_o), 32'hA00F);
    ctl_wr_ack_i = 1'b1;
    tick;
    ctl_wr_ack_i = 1'b0;
    chk("gap_wreq_low", 32'(ctl_wreq_o),  32'd0);
    chk("wr_done",      32'(done_o),      32'd1);
    chk("gap_cmd_rdy",  32'(cmd_ready_o), 32'd0);
    chk("wr_no_err",    32'(err_o),       32'd0);
    tick;
    chk("wr_done_pulse", 32'(done_o),      32'd0);
    chk("wr_idle_rdy",   32'(cmd_ready_o), 32'd1);
    chk("idle_wreq",     32'(ctl_wreq_o),  32'd0);
    chk("idle_rreq",     32'(ctl_rreq_o),  32'd0);

    // Back-to-back read burst from 0x3FFF0 with 18 strobes, ack on the last
    cmd_valid_i = 1'b1; cmd_rw_i = 1'b0; cmd_addr_i = 18'h3FFF0;
    tick;
    cmd_valid_i = 1'b0;
    chk("rreq_rise", 32'(ctl_rreq_o),    32'd1);
    chk("rd_addr",   32'(ctl_rd_addr_o), 32'h3FFF0);
    chk("rd_wreq",   32'(ctl_wreq_o),    32'd0);
    for (int k = 0; k < 18; k++) begin
      ctl_rd_valid_i = 1'b1; ctl_rdata_i = 16'(32'h5500 + k);
      ctl_rd_ack_i = (k == 17);
      tick;
    end
    ctl_rd_valid_i = 1'b0; ctl_rd_ack_i = 1'b0;
    chk("rreq_drop",   32'(ctl_rreq_o),  32'd0);
    chk("drain_valid", 32'(out_valid_o), 32'd1);
    chk("rd_no_done",  32'(done_o),      32'd0);
    for (int k = 0; k < 16; k++) begin
      out_ready_i = 1'b0;
      tick;
      chk("drain_stall",   32'(out_data_o), 32'h5500 + 32'(k));
      chk("drain_no_done", 32'(done_o),     32'd0);
      out_ready_i = 1'b1;
      chk("drain_data", 32'(out_data_o), 32'h5500 + 32'(k));
      tick;
    end
    out_ready_i = 1'b0;
    chk("rd_done",       32'(done_o),      32'd1);
    chk("drain_closed",  32'(out_valid_o), 32'd0);
    tick;
    chk("rd_done_pulse", 32'(done_o),      32'd0);
    chk("rd_idle_rdy",   32'(cmd_ready_o), 32'd1);

    // Read with no ack: abort after TIMEOUT cycles
    cmd_valid_i = 1'b1; cmd_rw_i = 1'b0; cmd_addr_i = 18'h01234;
    tick;
    cmd_valid_i = 1'b0;
    chk("to_rreq", 32'(ctl_rreq_o), 32'd1);
    repeat (TIMEOUT - 1) tick;
    chk("to_rreq_hold", 32'(ctl_rreq_o), 32'd1);
    chk("to_no_err",    32'(err_o),      32'd0);
    tick;
    chk("to_err",       32'(err_o),       32'd1);
    chk("to_rreq_drop", 32'(ctl_rreq_o),  32'd0);
    chk("to_no_done",   32'(done_o),      32'd0);
    chk("to_no_drain",  32'(out_valid_o), 32'd0);
    tick;
    chk("to_err_pulse", 32'(err_o),       32'd0);
    chk("to_idle_rdy",  32'(cmd_ready_o), 32'd1);

    // Next command accepted, then reset mid-FILL
    cmd_valid_i = 1'b1; cmd_rw_i = 1'b1; cmd_addr_i = 18'h00200;
    tick;
    cmd_valid_i = 1'b0;
    chk("post_to_fill", 32'(in_ready_o),    32'd1);
    chk("post_to_addr", 32'(ctl_wr_addr_o), 32'h200);
    for (int k = 0; k < 3; k++) begin
      in_valid_i = 1'b1; in_data_i = 16'(32'hB000 + k);
      tick;
    end
    in_valid_i = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rstf_in_ready", 32'(in_ready_o),    32'd0);
    chk("rstf_cmd_rdy",  32'(cmd_ready_o),   32'd0);
    chk("rstf_addr",     32'(ctl_wr_addr_o), 32'd0);
    tick;
    sys_rst_n = 1'b1;
    chk("rstf_rel_low", 32'(cmd_ready_o), 32'd0);
    tick;
    chk("rstf_rel_rdy", 32'(cmd_ready_o), 32'd1);
    chk("rstf_no_fill", 32'(in_ready_o),  32'd0);

    // Reset mid-DRAIN
    cmd_valid_i = 1'b1; cmd_rw_i = 1'b0; cmd_addr_i = 18'h00777;
    tick;
    cmd_valid_i = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ctl_rd_valid_i = 1'b1; ctl_rdata_i = 16'(32'h7700 + k);
      ctl_rd_ack_i = (k == 15);
      tick;
    end
    ctl_rd_valid_i = 1'b0; ctl_rd_ack_i = 1'b0;
    out_ready_i = 1'b1;
    tick; tick;
    out_ready_i = 1'b0;
    chk("rstd_pre_valid", 32'(out_valid_o), 32'd1);
    chk("rstd_pre_data",  32'(out_data_o),  32'h7702);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rstd_valid", 32'(out_valid_o),   32'd0);
    chk("rstd_data",  32'(out_data_o),    32'd0);
    chk("rstd_done",  32'(done_o),        32'd0);
    chk("rstd_addr",  32'(ctl_rd_addr_o), 32'd0);
    tick;
    sys_rst_n = 1'b1;
    tick;
    chk("rstd_rel_rdy", 32'(cmd_ready_o), 32'd1);
    chk("rstd_no_done", 32'(done_o),      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_burst_master.md
# sram_burst_master

Host-side burst client for the 256K x 16 asynchronous SRAM controller. It accepts read and write burst commands from a system master, issues edge-detected `rreq`/`wreq` requests to the controller, and supplies write data or captures read data on the controller's per-word valid strobes. Data moves through a BURST-deep local buffer. It sits between the system datapath and the SRAM controller's system-side port.

## Interface
- BURST, 16, words per transaction (power of two, 2..256)
- AW, 18, SRAM word address width
- DW, 16, data width
- TIMEOUT, 255, max cycles waiting for ack before abort (1..65535)

- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when both high
- cmd_rw_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  AW  burst start address
- in_valid_i / in_ready_o / in_data_i  in/out/in  1/1/DW  write-data stream
- out_valid_o / out_ready_i / out_data_o  out/in/out  1/1/DW  read-data stream
- done_o  out  1  one-cycle pulse, transaction completed
- err_o  out  1  one-cycle pulse, transaction aborted on timeout
- ctl_rreq_o, ctl_wreq_o  out  1  read/write request levels to controller
- ctl_rd_addr_o, ctl_wr_addr_o  out  AW  burst start address
- ctl_wdata_o  out  DW  current write word
- ctl_rdata_i  in  DW  read word from controller
- ctl_rd_valid_i, ctl_wr_valid_i  in  1  per-word data strobes
- ctl_rd_ack_i, ctl_wr_ack_i  in  1  transaction-end acknowledges

## Operation
- States: IDLE, FILL, WREQ, RREQ, DRAIN, GAP.
- IDLE: cmd_ready_o=1. On handshake, register cmd_addr_i into both ctl address outputs. Write -> FILL. Read -> RREQ.
- FILL: in_ready_o=1. Store words into buf[0..BURST-1]. After the BURST-th accepted word -> WREQ.
- WREQ: ctl_wreq_o=1. wptr starts at 0. ctl_wdata_o=buf[wptr]. wptr increments on each cycle with ctl_wr_valid_i=1 and saturates at BURST-1. ctl_wr_ack_i -> GAP with done_o.
- RREQ: ctl_rreq_o=1. rcnt starts at 0. On ctl_rd_valid_i with rcnt<BURST: buf[rcnt]<=ctl_rdata_i and rcnt++. Extra strobes are ignored. ctl_rd_ack_i -> DRAIN.
- DRAIN: out_valid_o=1 and out_data_o=buf[optr]. optr advances on out handshake. Handshake on word BURST-1 -> GAP with done_o.
- GAP: both requests low for exactly one cycle, so the controller sees a fresh rising edge next time. Then -> IDLE.
- Timeout: a counter clears on entry to WREQ/RREQ and increments every cycle there. Reaching TIMEOUT without the matching ack -> GAP with err_o, and no done_o. A read timeout discards the buffer (no DRAIN).
- An ack of the opposite direction is ignored. Acks in IDLE/FILL/DRAIN/GAP are ignored.
- Read ack arriving with rcnt<BURST: DRAIN still emits all BURST words. Unfilled entries hold stale contents. This is not an error.

## Timing
- Reset: all outputs 0, addresses 0, state IDLE, counters 0. cmd_ready_o goes to 1 on the first clock after release. Buffer contents are undefined.
- Reset asserted mid-transaction takes effect immediately. Requests drop asynchronously and no done_o/err_o is produced.
- All outputs are registered except ctl_wdata_o, out_data_o and the ready/valid outputs, which are decoded from registered state and pointers.
- Read: command handshake at cycle N -> ctl_rreq_o=1 at N+1.
- Write: last FILL word at cycle M -> ctl_wreq_o=1 at M+1.
- A data strobe coinciding with the ack is still captured or advanced.
- Ack sampled at A -> request low at A+1.
  - Write: done_o at A+1 (GAP). cmd_ready_o=1 at A+2.
  - Read: out_valid_o=1 at A+1.
- Final DRAIN handshake at D -> done_o at D+1. cmd_ready_o=1 at D+2.
- Timeout: with TIMEOUT=T, entry at E and no ack -> err_o and request low at E+T.
- No back-to-back commands: minimum spacing is ack + 2 cycles.

## Test plan
- Write burst, addr 0x00100, data 0xA000..0xA00F, controller model strobes wr_valid 16 cycles then acks -> ctl_wdata_o sequence 0xA000..0xA00F, one done_o, ctl_wreq_o high only WREQ cycles.
- Read burst, addr 0x3FFF0, model returns 0x5500+k, out_ready_i toggling 1/0 -> out_data_o 0x5500..0x550F in order, done_o one cycle after last handshake.
- Back-to-back write then read -> ctl_wreq_o low exactly one GAP cycle before IDLE, rreq rising edge present, both complete.
- No ack with TIMEOUT=20 -> err_o at entry+20, request dropped, no done_o, next command accepted two cycles later.
- Read with 18 rd_valid strobes (last with ack) -> only first 16 words stored. Opposite-direction ack during WREQ -> ignored, no state change.
- sys_rst_n low mid-FILL and mid-DRAIN -> all outputs 0 immediately, cmd_ready_o=1 first clock after release.
